// File: rtl/relu_maxpool16_if.sv
// Stream bundle between the conv unit, relu_maxpool16 and the next layer's window logic.
interface relu_maxpool16_if;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        frame_done;

  modport master (output clear, in_valid, in_data, input out_data, out_valid, frame_done);
  modport slave  (input clear, in_valid, in_data, output out_data, out_valid, frame_done);
endinterface

// File: rtl/relu_maxpool16.sv
// Optional ReLU (macro RELU_EN) then 2x2 stride-2 float16 max pool over a raster stream using a half-width row buffer.
// Output strobe 1 cycle after each window's bottom-right input; no stalls, no backpressure (consumer takes every strobe).
module relu_maxpool16 #(
  parameter int data_width  = 16,
  parameter int fmap_width  = 26,
  parameter int fmap_height = 26
) (
  input  logic            clk,
  input  logic            reset,
  relu_maxpool16_if.slave bus
);
  localparam int DW = data_width;
  localparam int PW = fmap_width / 2;
  localparam int PH = fmap_height / 2;
  localparam int CW = $clog2(fmap_width + 1);
  localparam int RW = $clog2(fmap_height + 1);
  localparam int BW = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [CW-1:0] COL_LAST      = CW'(fmap_width - 1);
  localparam logic [CW-1:0] COL_PAIR_END  = CW'(2 * PW);
  localparam logic [RW-1:0] ROW_LAST      = RW'(fmap_height - 1);
  localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * PH - 1);
  localparam bit            H_ODD         = (fmap_height % 2) == 1;

  typedef enum logic [1:0] {ROW_EVEN, ROW_ODD, ROW_DROP} row_state_e;

  function automatic logic [DW-1:0] activate(input logic [DW-1:0] x);
`ifdef RELU_EN
    return x[DW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  // a is the earlier operand and survives every tie, including +0 vs -0.
  function automatic logic [DW-1:0] fmax(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef RELU_EN
    return (b[DW-2:0] > a[DW-2:0]) ? b : a;
`else
    logic [DW-1:0] r;
    r = a;
    if (a[DW-2:0] == '0 && b[DW-2:0] == '0) r = a;
    else if (a[DW-1] != b[DW-1])            r = a[DW-1] ? b : a;
    else if (!a[DW-1])                      r = (b[DW-2:0] > a[DW-2:0]) ? b : a;
    else                                    r = (b[DW-2:0] < a[DW-2:0]) ? b : a;
    return r;
`endif
  endfunction

  row_state_e    state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [DW-1:0] pair_q;
  logic [DW-1:0] out_data_q;
  logic          out_valid_q;
  logic          frame_done_q;
  logic [DW-1:0] row_buf_q [2**BW];

  logic [DW-1:0] act;
  logic [DW-1:0] pair_max;
  logic [DW-1:0] win_max;
  logic [BW-1:0] buf_idx;
  logic          col_odd;
  logic          take;

  assign take     = bus.in_valid && !bus.clear;
  assign col_odd  = col_q[0];
  assign buf_idx  = BW'(col_q >> 1);
  assign act      = activate(bus.in_data);
  assign pair_max = fmax(pair_q, act);
  assign win_max  = fmax(row_buf_q[buf_idx], pair_max);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ROW_EVEN;
      col_q        <= '0;
      row_q        <= '0;
      pair_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      if (bus.clear) begin
        state_q <= ROW_EVEN;
        col_q   <= '0;
        row_q   <= '0;
      end else if (bus.in_valid) begin
        // A trailing odd column never loads the pair register.
        if (col_odd)                      pair_q <= pair_max;
        else if (col_q < COL_PAIR_END)    pair_q <= act;
        if (state_q == ROW_ODD && col_odd) begin
          out_data_q  <= win_max;
          out_valid_q <= 1'b1;
        end
        if (col_q == COL_LAST) begin
          col_q        <= '0;
          row_q        <= (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
          frame_done_q <= (row_q == ROW_LAST);
          case (state_q)
            ROW_EVEN: state_q <= ROW_ODD;
            ROW_ODD:  state_q <= (H_ODD && row_q == ROW_POOL_LAST) ? ROW_DROP : ROW_EVEN;
            default:  state_q <= ROW_EVEN;
          endcase
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

  // Entries are always rewritten in an even row before the odd row reads them, so no reset.
  always_ff @(posedge clk) begin
    if (take && state_q == ROW_EVEN && col_odd)
      row_buf_q[buf_idx] <= pair_max;
  end

  assign bus.out_data   = out_data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule
